// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - bus bundle between requesters, ALU and alu_share_arbiter
// Purpose: groups the two requester issue ports, the two response ports and the
//   ALU-side operand/result signals of alu_share_arbiter into one interface.
// Signal directions are named from the arbiter's point of view (_i in, _o out).
// Ports (signals):
//   reqN_valid_i/reqN_ready_o     issue handshake of requester N (N=0,1)
//   reqN_data1_i/reqN_data2_i     32-bit signed operands
//   reqN_ctrl_i                   3-bit ALU op code
//   rspN_valid_o/data_o/zero_o    one-cycle result pulse, result, zero flag
//   alu_data1_o/data2_o/ctrl_o    operands and op code towards the ALU
//   alu_data_i/alu_zero_i         result and zero flag from the ALU
// Modports: slave = arbiter side, master = requester/ALU side.
interface alu_share_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_data1_i;
  logic [31:0] req0_data2_i;
  logic [2:0]  req0_ctrl_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_data1_i;
  logic [31:0] req1_data2_i;
  logic [2:0]  req1_ctrl_i;
  logic        rsp0_valid_o;
  logic [31:0] rsp0_data_o;
  logic        rsp0_zero_o;
  logic        rsp1_valid_o;
  logic [31:0] rsp1_data_o;
  logic        rsp1_zero_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data_i;
  logic        alu_zero_i;

  modport slave (
    input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    input  alu_data_i, alu_zero_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
    output rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
    output alu_data1_o, alu_data2_o, alu_ctrl_o
  );

  modport master (
    output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    output alu_data_i, alu_zero_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
    input  rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 32-bit ALU between two requesters
// Purpose: arbitrates two requesters onto one combinational ALU with a valid/ready
//   issue handshake, registered operands and registered per-requester results.
//   MUL (ctrl 3'd6) holds the ALU for MUL_LATENCY cycles so the multiplier can be
//   timed as a multicycle path; all other ops hold it for one cycle.
// Ports:
//   clk_i   clock, all state on rising edge
//   rst_i   synchronous reset, active-high
//   bus     alu_share_arbiter_if.slave: requester issue ports, response ports, ALU side
module alu_share_arbiter #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_share_arbiter_if.slave bus
);

  localparam logic [2:0] CTRL_MUL = 3'd6;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LATENCY);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_data1_q, op_data1_d;
  logic [31:0] op_data2_q, op_data2_d;
  logic [2:0]  op_ctrl_q, op_ctrl_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;
  logic        rsp0_zero_q, rsp0_zero_d;
  logic        rsp1_zero_q, rsp1_zero_d;

  logic accept_win;
  logic grant0, grant1;
  logic ready0, ready1;
  logic [2:0] sel_ctrl;

  always_comb begin
    // Last cycle of the current op doubles as an issue slot for the next one.
    accept_win = (state_q == IDLE) || (cnt_q == 4'd1);
    // On contention the requester that was not granted last wins.
    grant0 = bus.req0_valid_i && (!bus.req1_valid_i || last_q);
    grant1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
    ready0 = grant0 && accept_win && !rst_i;
    ready1 = grant1 && accept_win && !rst_i;
    sel_ctrl = ready1 ? bus.req1_ctrl_i : bus.req0_ctrl_i;

    state_d      = state_q;
    cnt_d        = cnt_q;
    op_data1_d   = op_data1_q;
    op_data2_d   = op_data2_q;
    op_ctrl_d    = op_ctrl_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_zero_d  = rsp1_zero_q;

    if (state_q == EXEC) begin
      if (cnt_q == 4'd1) begin
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = bus.alu_data_i;
          rsp1_zero_d  = bus.alu_zero_i;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = bus.alu_data_i;
          rsp0_zero_d  = bus.alu_zero_i;
        end
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    // Accept overrides the IDLE transition above when issuing back-to-back.
    if (ready0 || ready1) begin
      op_data1_d = ready1 ? bus.req1_data1_i : bus.req0_data1_i;
      op_data2_d = ready1 ? bus.req1_data2_i : bus.req0_data2_i;
      op_ctrl_d  = sel_ctrl;
      owner_d    = ready1;
      last_d     = ready1;
      cnt_d      = (sel_ctrl == CTRL_MUL) ? MUL_CNT : 4'd1;
      state_d    = EXEC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      op_data1_q   <= 32'd0;
      op_data2_q   <= 32'd0;
      op_ctrl_q    <= 3'd0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
      rsp0_zero_q  <= 1'b0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_data1_q   <= op_data1_d;
      op_data2_q   <= op_data2_d;
      op_ctrl_q    <= op_ctrl_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.rsp0_valid_o = rsp0_valid_q;
  assign bus.rsp0_data_o  = rsp0_data_q;
  assign bus.rsp0_zero_o  = rsp0_zero_q;
  assign bus.rsp1_valid_o = rsp1_valid_q;
  assign bus.rsp1_data_o  = rsp1_data_q;
  assign bus.rsp1_zero_o  = rsp1_zero_q;
  assign bus.alu_data1_o  = op_data1_q;
  assign bus.alu_data2_o  = op_data2_q;
  assign bus.alu_ctrl_o   = op_ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
// Purpose: two arbiter instances (MUL_LATENCY 2 and 1) driven by directed vectors,
//   each attached to a behavioural ALU; every result is compared to a hand-computed value.
// Ports: none (top-level bench).
module tb_alu_share_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_share_arbiter_if bus_a ();
  alu_share_arbiter_if bus_b ();

  alu_share_arbiter #(.MUL_LATENCY(2)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  alu_share_arbiter #(.MUL_LATENCY(1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    case (c)
      3'd1: sr = sa & sb;
      3'd2: sr = sa ^ sb;
      3'd3: sr = sa << b[4:0];
      3'd4: sr = sa + sb;
      3'd5: sr = sa - sb;
      3'd6: sr = sa * sb;
      3'd7: sr = sa >>> b[4:0];
      default: sr = 32'sd0;
    endcase
    return sr;
  endfunction

  always_comb begin
    bus_a.alu_data_i = alu_fn(bus_a.alu_ctrl_o, bus_a.alu_data1_o, bus_a.alu_data2_o);
    bus_a.alu_zero_i = (bus_a.alu_ctrl_o == 3'd5) && (bus_a.alu_data1_o == bus_a.alu_data2_o);
    bus_b.alu_data_i = alu_fn(bus_b.alu_ctrl_o, bus_b.alu_data1_o, bus_b.alu_data2_o);
    bus_b.alu_zero_i = (bus_b.alu_ctrl_o == 3'd5) && (bus_b.alu_data1_o == bus_b.alu_data2_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a0(input logic v, input logic [2:0] c, input logic [31:0] d1, input logic [31:0] d2);
    bus_a.req0_valid_i = v;
    bus_a.req0_ctrl_i  = c;
    bus_a.req0_data1_i = d1;
    bus_a.req0_data2_i = d2;
  endtask

  task automatic drive_a1(input logic v, input logic [2:0] c, input logic [31:0] d1, input logic [31:0] d2);
    bus_a.req1_valid_i = v;
    bus_a.req1_ctrl_i  = c;
    bus_a.req1_data1_i = d1;
    bus_a.req1_data2_i = d2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a0(1'b1, 3'd4, 32'd1, 32'd1);
    drive_a1(1'b1, 3'd4, 32'd2, 32'd2);
    cyc();
    cyc();
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b0 || bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 00", bus_a.req0_ready_o, bus_a.req1_ready_o);
    end
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b0 || bus_a.rsp1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b%b exp 00", bus_a.rsp0_valid_o, bus_a.rsp1_valid_o);
    end
    checks++;
    if (bus_a.rsp0_data_o !== 32'd0 || bus_a.rsp1_data_o !== 32'd0 || bus_a.rsp0_zero_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_data got %h %h exp 0 0", bus_a.rsp0_data_o, bus_a.rsp1_data_o);
    end
    checks++;
    if (bus_a.alu_ctrl_o !== 3'd0 || bus_a.alu_data1_o !== 32'd0 || bus_a.alu_data2_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu_ops got %h %h %h exp 0 0 0", bus_a.alu_ctrl_o, bus_a.alu_data1_o, bus_a.alu_data2_o);
    end
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_add();
    drive_a0(1'b1, 3'd4, 32'd5, 32'd7);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b1 || bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL add_ready got %b%b exp 10", bus_a.req0_ready_o, bus_a.req1_ready_o);
    end
    cyc();
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b0 || bus_a.alu_ctrl_o !== 3'd4) begin
      errors++;
      $display("FAIL add_t1 got valid %b ctrl %0d exp 0 4", bus_a.rsp0_valid_o, bus_a.alu_ctrl_o);
    end
    cyc();
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b1 || bus_a.rsp0_data_o !== 32'd12 || bus_a.rsp0_zero_o !== 1'b0 || bus_a.rsp1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp got v%b d%0d z%b v1%b exp v1 d12 z0 v1 0", bus_a.rsp0_valid_o, bus_a.rsp0_data_o, bus_a.rsp0_zero_o, bus_a.rsp1_valid_o);
    end
    cyc();
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse got %b exp 0", bus_a.rsp0_valid_o);
    end
  endtask

  task automatic test_sub_sra();
    logic [2:0]  c_tab [3];
    logic [31:0] d1_tab [3];
    logic [31:0] d2_tab [3];
    logic [31:0] r_tab [3];
    logic        z_tab [3];
    c_tab  = '{3'd5, 3'd5, 3'd7};
    d1_tab = '{32'd9, 32'd9, 32'hFFFF_FFF8};
    d2_tab = '{32'd9, 32'd4, 32'd1};
    r_tab  = '{32'd0, 32'd5, 32'hFFFF_FFFC};
    z_tab  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_a1(1'b1, c_tab[i], d1_tab[i], d2_tab[i]);
      else drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      if (i < 3) begin
        checks++;
        if (bus_a.req1_ready_o !== 1'b1 || bus_a.req0_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL sub_ready[%0d] got %b%b exp 01", i, bus_a.req0_ready_o, bus_a.req1_ready_o);
        end
      end
      if (i >= 2) begin
        checks++;
        if (bus_a.rsp1_valid_o !== 1'b1 || bus_a.rsp1_data_o !== r_tab[i-2] || bus_a.rsp1_zero_o !== z_tab[i-2] || bus_a.rsp0_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL sub_rsp[%0d] got v%b d%h z%b exp v1 d%h z%b", i - 2, bus_a.rsp1_valid_o, bus_a.rsp1_data_o, bus_a.rsp1_zero_o, r_tab[i-2], z_tab[i-2]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_own;
    logic [31:0] exp_data;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive_a0(1'b1, 3'd4, 32'(i), 32'd100);
        drive_a1(1'b1, 3'd4, 32'(i), 32'd200);
      end else begin
        drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
        drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
      end
      #1;
      if (i < 4) begin
        checks++;
        if (bus_a.req0_ready_o !== (i % 2 == 0) || bus_a.req1_ready_o !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL rr_ready[%0d] got %b%b exp %b%b", i, bus_a.req0_ready_o, bus_a.req1_ready_o, (i % 2 == 0), (i % 2 == 1));
        end
      end
      if (i >= 2) begin
        exp_own  = ((i - 2) % 2 == 1);
        exp_data = 32'(i - 2) + (exp_own ? 32'd200 : 32'd100);
        checks++;
        if (bus_a.rsp0_valid_o !== !exp_own || bus_a.rsp1_valid_o !== exp_own ||
            (exp_own ? bus_a.rsp1_data_o : bus_a.rsp0_data_o) !== exp_data) begin
          errors++;
          $display("FAIL rr_rsp[%0d] got v%b%b d0 %0d d1 %0d exp owner %b data %0d", i, bus_a.rsp0_valid_o, bus_a.rsp1_valid_o, bus_a.rsp0_data_o, bus_a.rsp1_data_o, exp_own, exp_data);
        end
      end else begin
        checks++;
        if (bus_a.rsp0_valid_o !== 1'b0 || bus_a.rsp1_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rr_early[%0d] got %b%b exp 00", i, bus_a.rsp0_valid_o, bus_a.rsp1_valid_o);
        end
      end
      cyc();
    end
  endtask

  task automatic test_mul_hold();
    drive_a0(1'b1, 3'd6, 32'd6, 32'd7);
    drive_a1(1'b1, 3'd4, 32'd1, 32'd1);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b1 || bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_t0_ready got %b%b exp 10", bus_a.req0_ready_o, bus_a.req1_ready_o);
    end
    cyc();
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_t1_ready1 got %b exp 0", bus_a.req1_ready_o);
    end
    cyc();
    checks++;
    if (bus_a.req1_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_t2_ready1 got %b exp 1", bus_a.req1_ready_o);
    end
    cyc();
    drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b1 || bus_a.rsp0_data_o !== 32'd42 || bus_a.rsp1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_rsp0 got v%b d%0d v1 %b exp v1 d42 v1 0", bus_a.rsp0_valid_o, bus_a.rsp0_data_o, bus_a.rsp1_valid_o);
    end
    cyc();
    checks++;
    if (bus_a.rsp1_valid_o !== 1'b1 || bus_a.rsp1_data_o !== 32'd2 || bus_a.rsp0_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_rsp1 got v%b d%0d v0 %b exp v1 d2 v0 0", bus_a.rsp1_valid_o, bus_a.rsp1_data_o, bus_a.rsp0_valid_o);
    end
    drive_a0(1'b1, 3'd6, 32'hFFFF_FFFD, 32'd5);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_neg_ready got %b exp 1", bus_a.req0_ready_o);
    end
    cyc();
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_neg_early got %b exp 0", bus_a.rsp0_valid_o);
    end
    cyc();
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b1 || bus_a.rsp0_data_o !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mul_neg_rsp got v%b d%h exp v1 dfffffff1", bus_a.rsp0_valid_o, bus_a.rsp0_data_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    drive_a0(1'b1, 3'd6, 32'd6, 32'd7);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_accept got %b exp 1", bus_a.req0_ready_o);
    end
    cyc();
    rst = 1'b1;
    drive_a1(1'b1, 3'd4, 32'd3, 32'd4);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b0 || bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready got %b%b exp 00", bus_a.req0_ready_o, bus_a.req1_ready_o);
    end
    cyc();
    checks++;
    if (bus_a.req0_ready_o !== 1'b0 || bus_a.req1_ready_o !== 1'b0 || bus_a.rsp0_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got r%b%b v%b exp r00 v0", bus_a.req0_ready_o, bus_a.req1_ready_o, bus_a.rsp0_valid_o);
    end
    cyc();
    rst = 1'b0;
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b0 || bus_a.rsp0_data_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_no_rsp got v%b d%0d exp v0 d0", bus_a.rsp0_valid_o, bus_a.rsp0_data_o);
    end
    cyc();
    drive_a0(1'b1, 3'd4, 32'd1, 32'd2);
    drive_a1(1'b1, 3'd4, 32'd3, 32'd4);
    #1;
    checks++;
    if (bus_a.req0_ready_o !== 1'b1 || bus_a.req1_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_first got %b%b exp 10", bus_a.req0_ready_o, bus_a.req1_ready_o);
    end
    cyc();
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    checks++;
    if (bus_a.rsp0_valid_o !== 1'b1 || bus_a.rsp0_data_o !== 32'd3) begin
      errors++;
      $display("FAIL rst_mid_rsp got v%b d%0d exp v1 d3", bus_a.rsp0_valid_o, bus_a.rsp0_data_o);
    end
    cyc();
  endtask

  task automatic test_mul_lat1();
    logic [31:0] exp_tab [2];
    exp_tab = '{32'd42, 32'd6};
    for (int i = 0; i < 5; i++) begin
      bus_b.req0_valid_i = (i < 2);
      bus_b.req0_ctrl_i  = (i < 2) ? 3'd6 : 3'd0;
      bus_b.req0_data1_i = (i == 0) ? 32'd6 : 32'd2;
      bus_b.req0_data2_i = (i == 0) ? 32'd7 : 32'd3;
      #1;
      if (i < 2) begin
        checks++;
        if (bus_b.req0_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL lat1_ready[%0d] got %b exp 1", i, bus_b.req0_ready_o);
        end
      end
      if (i >= 2 && i < 4) begin
        checks++;
        if (bus_b.rsp0_valid_o !== 1'b1 || bus_b.rsp0_data_o !== exp_tab[i-2]) begin
          errors++;
          $display("FAIL lat1_rsp[%0d] got v%b d%0d exp v1 d%0d", i - 2, bus_b.rsp0_valid_o, bus_b.rsp0_data_o, exp_tab[i-2]);
        end
      end else begin
        checks++;
        if (bus_b.rsp0_valid_o !== 1'b0 || bus_b.rsp1_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL lat1_idle[%0d] got %b%b exp 00", i, bus_b.rsp0_valid_o, bus_b.rsp1_valid_o);
        end
      end
      cyc();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_a0(1'b0, 3'd0, 32'd0, 32'd0);
    drive_a1(1'b0, 3'd0, 32'd0, 32'd0);
    bus_b.req0_valid_i = 1'b0;
    bus_b.req0_ctrl_i  = 3'd0;
    bus_b.req0_data1_i = 32'd0;
    bus_b.req0_data2_i = 32'd0;
    bus_b.req1_valid_i = 1'b0;
    bus_b.req1_ctrl_i  = 3'd0;
    bus_b.req1_data1_i = 32'd0;
    bus_b.req1_data2_i = 32'd0;
    cyc();
    test_reset();
    test_single_add();
    test_sub_sra();
    test_back_to_back();
    test_mul_hold();
    test_reset_mid_op();
    test_mul_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
